// File: rtl/opll_pkg.sv
// Shared constants, register-file address map and per-channel record
// for the OPLL host-bus front end.
package opll_pkg;

    localparam int NUM_CH     = 9;
    localparam int NUM_SLOTS  = 18;
    localparam int RESET_HOLD = 72;

    localparam logic [7:0] ADDR_PATCH_LAST = 8'h07;
    localparam logic [7:0] ADDR_RHYTHM     = 8'h0E;
    localparam logic [7:0] ADDR_TEST       = 8'h0F;
    localparam logic [3:0] GRP_FNUM        = 4'h1;
    localparam logic [3:0] GRP_CTRL        = 4'h2;
    localparam logic [3:0] GRP_INST        = 4'h3;

    typedef struct packed {
        logic [8:0] fnum;
        logic [2:0] block;
        logic       kon;
        logic       susen;
        logic [3:0] inst;
        logic [3:0] vol;
    } ch_regs_t;

    function automatic logic is_ch_addr(input logic [7:0] a);
        return ((a[7:4] == GRP_FNUM) || (a[7:4] == GRP_CTRL) ||
                (a[7:4] == GRP_INST)) && (a[3:0] <= 4'd8);
    endfunction

    function automatic logic is_grp(input logic [7:0] a,
                                    input logic [3:0] grp);
        return is_ch_addr(a) && (a[7:4] == grp);
    endfunction

endpackage

// File: rtl/opll_bus_if.sv
// Host-bus synchroniser and write capture; emits one-clock address/data
// commit pulses on the release edge of the write strobe.
module opll_bus_if #(
    parameter bit FULLY_SYNCHRONOUS = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_n,
    input  logic       wr_n,
    input  logic       a0,
    input  logic [7:0] d,
    output logic       wr_addr,
    output logic       wr_data,
    output logic [7:0] wdata
);

    logic [9:0] s1_q, s1_d, s2_q, s2_d, samp;
    logic [8:0] cap_q, cap_d;
    logic [1:0] fill_q, fill_d;
    logic       strb_q, strb_d, armed_q, armed_d;
    logic       strb, full, commit;

    always_comb begin
        s1_d   = {~cs_n & ~wr_n, a0, d};
        s2_d   = s1_q;
        samp   = FULLY_SYNCHRONOUS ? s2_q : s1_q;
        full   = FULLY_SYNCHRONOUS ? fill_q[1] : fill_q[0];
        strb   = samp[9];
        fill_d = {fill_q[0], 1'b1};
        strb_d = strb;
        cap_d  = strb ? samp[8:0] : cap_q;
        // A strobe already high when the pipe fills never arms a commit
        armed_d = armed_q | (full & ~strb);
        commit  = strb_q & ~strb & armed_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= '0;
            s2_q    <= '0;
            cap_q   <= '0;
            fill_q  <= '0;
            strb_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            cap_q   <= cap_d;
            fill_q  <= fill_d;
            strb_q  <= strb_d;
            armed_q <= armed_d;
        end
    end

    assign wr_addr = commit & ~cap_q[8];
    assign wr_data = commit & cap_q[8];
    assign wdata   = cap_q[7:0];

endmodule

// File: rtl/opll_bus_regfile.sv
// YM2413 bus front end: register file plus 9-channel phiM parameter scan.
// Optional OPLL_DBG_READBACK_EN adds a combinational debug read port.
module opll_bus_regfile
    import opll_pkg::*;
#(
    parameter bit FULLY_SYNCHRONOUS    = 1'b1,
    parameter bit FAST_RESET           = 1'b1,
    parameter bit ALTPATCH_CONFIG_MODE = 1'b0
) (
    input  logic        i_XIN_EMUCLK,
    input  logic        i_IC_n,
    output logic        o_XOUT,
    input  logic        i_phiM_PCEN_n,
    input  logic        i_ALTPATCH_EN,
    input  logic        i_CS_n,
    input  logic        i_WR_n,
    input  logic        i_A0,
    input  logic [7:0]  i_D,
    output logic [7:0]  o_D,
    output logic        o_D_OE,
    output logic        o_ALTPATCH,
    output logic [63:0] o_PATCH,
    output logic [5:0]  o_RHYTHM,
    output logic [7:0]  o_TEST,
    output logic        o_SYNC,
    output logic [3:0]  o_CH,
    output logic [8:0]  o_FNUM,
    output logic [2:0]  o_BLOCK,
    output logic        o_KON,
    output logic        o_SUSEN,
    output logic [3:0]  o_INST,
`ifdef OPLL_DBG_READBACK_EN
    input  logic [7:0]  i_DBG_ADDR,
    output logic [7:0]  o_DBG_DATA,
`endif
    output logic [3:0]  o_VOL
);

    logic       wr_addr, wr_data, data_ok, pcen;
    logic [7:0] wdata;
    logic [3:0] idx;

    logic [7:0] addr_q, addr_d, test_q, test_d;
    logic [7:0] patch_q [8];
    logic [7:0] patch_d [8];
    logic [5:0] rhythm_q, rhythm_d;
    ch_regs_t   ch_q [NUM_CH];
    ch_regs_t   ch_d [NUM_CH];
    ch_regs_t   scan_q, scan_d;
    logic [4:0] slot_q, slot_d;
    logic       sync_q, sync_d;
    logic [6:0] hold_q, hold_d;
    logic       started_q, started_d;
    logic       alt_q, alt_d, alt_done_q, alt_done_d;

    opll_bus_if #(
        .FULLY_SYNCHRONOUS(FULLY_SYNCHRONOUS)
    ) u_bus_if (
        .clk    (i_XIN_EMUCLK),
        .rst_n  (i_IC_n),
        .cs_n   (i_CS_n),
        .wr_n   (i_WR_n),
        .a0     (i_A0),
        .d      (i_D),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wdata  (wdata)
    );

    assign pcen = ~i_phiM_PCEN_n;
    assign idx  = addr_q[3:0];

    always_comb begin
        addr_d     = addr_q;
        patch_d    = patch_q;
        rhythm_d   = rhythm_q;
        test_d     = test_q;
        ch_d       = ch_q;
        slot_d     = slot_q;
        sync_d     = sync_q;
        scan_d     = scan_q;
        hold_d     = hold_q;
        started_d  = 1'b1;
        alt_d      = alt_q;
        alt_done_d = 1'b1;

        if (!FAST_RESET) begin
            if (!started_q)
                hold_d = RESET_HOLD[6:0];
            else if (pcen && hold_q != 7'd0)
                hold_d = hold_q - 7'd1;
        end
        data_ok = wr_data &
                  (FAST_RESET || (started_q && hold_q == 7'd0));

        if (wr_addr)
            addr_d = wdata;

        if (data_ok) begin
            unique case (1'b1)
                (addr_q <= ADDR_PATCH_LAST):
                    patch_d[addr_q[2:0]] = wdata;
                (addr_q == ADDR_RHYTHM):
                    rhythm_d = wdata[5:0];
                (addr_q == ADDR_TEST):
                    test_d = wdata;
                is_grp(addr_q, GRP_FNUM):
                    ch_d[idx].fnum[7:0] = wdata;
                is_grp(addr_q, GRP_CTRL): begin
                    ch_d[idx].susen   = wdata[5];
                    ch_d[idx].kon     = wdata[4];
                    ch_d[idx].block   = wdata[3:1];
                    ch_d[idx].fnum[8] = wdata[0];
                end
                is_grp(addr_q, GRP_INST): begin
                    ch_d[idx].inst = wdata[7:4];
                    ch_d[idx].vol  = wdata[3:0];
                end
                default: ;
            endcase
        end

        // Scan reads the pre-commit array, so a same-clock write shows next pass
        if (pcen) begin
            slot_d = (slot_q == 5'(NUM_SLOTS - 1)) ? 5'd0 : slot_q + 5'd1;
            sync_d = (slot_d == 5'd0);
            scan_d = ch_q[slot_d[4:1]];
        end

        if (!ALTPATCH_CONFIG_MODE || !alt_done_q)
            alt_d = i_ALTPATCH_EN;
    end

    always_ff @(posedge i_XIN_EMUCLK or negedge i_IC_n) begin
        if (!i_IC_n) begin
            addr_q   <= '0;
            rhythm_q <= '0;
            test_q   <= '0;
            for (int i = 0; i < 8; i++)
                patch_q[i] <= '0;
            for (int i = 0; i < NUM_CH; i++)
                ch_q[i] <= '0;
            scan_q     <= '0;
            slot_q     <= '0;
            sync_q     <= 1'b0;
            hold_q     <= '0;
            started_q  <= 1'b0;
            alt_q      <= 1'b0;
            alt_done_q <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            rhythm_q   <= rhythm_d;
            test_q     <= test_d;
            patch_q    <= patch_d;
            ch_q       <= ch_d;
            scan_q     <= scan_d;
            slot_q     <= slot_d;
            sync_q     <= sync_d;
            hold_q     <= hold_d;
            started_q  <= started_d;
            alt_q      <= alt_d;
            alt_done_q <= alt_done_d;
        end
    end

    always_comb begin
        for (int i = 0; i < 8; i++)
            o_PATCH[i*8 +: 8] = patch_q[i];
    end

    assign o_XOUT     = ~i_XIN_EMUCLK;
    assign o_D        = addr_q;
    assign o_D_OE     = 1'b0;
    assign o_ALTPATCH = alt_q;
    assign o_RHYTHM   = rhythm_q;
    assign o_TEST     = test_q;
    assign o_SYNC     = sync_q;
    assign o_CH       = slot_q[4:1];
    assign o_FNUM     = scan_q.fnum;
    assign o_BLOCK    = scan_q.block;
    assign o_KON      = scan_q.kon;
    assign o_SUSEN    = scan_q.susen;
    assign o_INST     = scan_q.inst;
    assign o_VOL      = scan_q.vol;

`ifdef OPLL_DBG_READBACK_EN
    logic [3:0] dbg_idx;
    assign dbg_idx = i_DBG_ADDR[3:0];

    always_comb begin
        o_DBG_DATA = 8'h00;
        unique case (1'b1)
            (i_DBG_ADDR <= ADDR_PATCH_LAST):
                o_DBG_DATA = patch_q[i_DBG_ADDR[2:0]];
            (i_DBG_ADDR == ADDR_RHYTHM):
                o_DBG_DATA = {2'b00, rhythm_q};
            (i_DBG_ADDR == ADDR_TEST):
                o_DBG_DATA = test_q;
            is_grp(i_DBG_ADDR, GRP_FNUM):
                o_DBG_DATA = ch_q[dbg_idx].fnum[7:0];
            is_grp(i_DBG_ADDR, GRP_CTRL):
                o_DBG_DATA = {2'b00, ch_q[dbg_idx].susen,
                              ch_q[dbg_idx].kon, ch_q[dbg_idx].block,
                              ch_q[dbg_idx].fnum[8]};
            is_grp(i_DBG_ADDR, GRP_INST):
                o_DBG_DATA = {ch_q[dbg_idx].inst, ch_q[dbg_idx].vol};
            default: ;
        endcase
    end
`endif

endmodule

// File: tb/tb_opll_bus_regfile.sv
// Scoreboard bench for opll_bus_regfile: stimulus queues expectations,
// a monitor checks them at each phiM scan presentation.
module tb_opll_bus_regfile;

    localparam int K_ST   = 0;
    localparam int K_CH   = 1;
    localparam int K_SYNC = 2;

    localparam int S_PATCH  = 0;
    localparam int S_RHYTHM = 1;
    localparam int S_TEST   = 2;
    localparam int S_ADDR   = 3;
    localparam int S_ALT    = 4;
    localparam int S_MISC   = 5;
    localparam int S_XOUT   = 6;

    logic        clk = 1'b0;
    logic        ic_n = 1'b0;
    logic        pcen_n = 1'b1;
    logic        alt_en = 1'b0;
    logic        cs_n = 1'b1;
    logic        wr_n = 1'b1;
    logic        a0 = 1'b0;
    logic [7:0]  d = 8'h00;

    logic        o_XOUT, o_D_OE, o_ALTPATCH, o_SYNC, o_KON, o_SUSEN;
    logic [7:0]  o_D, o_TEST;
    logic [63:0] o_PATCH;
    logic [5:0]  o_RHYTHM;
    logic [3:0]  o_CH, o_INST, o_VOL;
    logic [8:0]  o_FNUM;
    logic [2:0]  o_BLOCK;
`ifdef OPLL_DBG_READBACK_EN
    logic [7:0]  dbg_addr = 8'h00;
    logic [7:0]  dbg_data;
`endif

    typedef struct {
        int          kind;
        int          sel;
        int          ch;
        logic [63:0] val;
        string       name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   en_cnt = 0;
    int   period = 0;
    bit   have_sync = 1'b0;

    opll_bus_regfile dut (
        .i_XIN_EMUCLK (clk),
        .i_IC_n       (ic_n),
        .o_XOUT       (o_XOUT),
        .i_phiM_PCEN_n(pcen_n),
        .i_ALTPATCH_EN(alt_en),
        .i_CS_n       (cs_n),
        .i_WR_n       (wr_n),
        .i_A0         (a0),
        .i_D          (d),
        .o_D          (o_D),
        .o_D_OE       (o_D_OE),
        .o_ALTPATCH   (o_ALTPATCH),
        .o_PATCH      (o_PATCH),
        .o_RHYTHM     (o_RHYTHM),
        .o_TEST       (o_TEST),
        .o_SYNC       (o_SYNC),
        .o_CH         (o_CH),
        .o_FNUM       (o_FNUM),
        .o_BLOCK      (o_BLOCK),
        .o_KON        (o_KON),
        .o_SUSEN      (o_SUSEN),
        .o_INST       (o_INST),
`ifdef OPLL_DBG_READBACK_EN
        .i_DBG_ADDR   (dbg_addr),
        .o_DBG_DATA   (dbg_data),
`endif
        .o_VOL        (o_VOL)
    );

    always #5 clk = ~clk;

    // phiM enable: low for one rising edge out of every four
    initial begin
        forever begin
            repeat (3) @(posedge clk);
            #1 pcen_n = 1'b0;
            @(posedge clk);
            #1 pcen_n = 1'b1;
        end
    end

    function automatic logic [63:0] static_val(input int sel);
        case (sel)
            S_PATCH:  return o_PATCH;
            S_RHYTHM: return 64'(o_RHYTHM);
            S_TEST:   return 64'(o_TEST);
            S_ADDR:   return 64'(o_D);
            S_ALT:    return 64'(o_ALTPATCH);
            S_XOUT:   return 64'(o_XOUT);
            default:  return 64'({o_D_OE, o_D, o_ALTPATCH, o_RHYTHM,
                                  o_TEST, o_SYNC, o_CH, o_FNUM, o_BLOCK,
                                  o_KON, o_SUSEN, o_INST, o_VOL});
        endcase
    endfunction

    function automatic logic [63:0] chv(input logic [8:0] fnum,
                                        input logic [2:0] blk,
                                        input logic kon, input logic sus,
                                        input logic [3:0] inst,
                                        input logic [3:0] vol);
        return 64'({fnum, blk, kon, sus, inst, vol});
    endfunction

    task automatic compare(input string name, input logic [63:0] act,
                           input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitor: each scan presentation retires every expectation it can
    initial begin
        exp_t e;
        bit   hit;
        forever begin
            @(posedge clk);
            if (!pcen_n) begin
                @(negedge clk);
                if (!ic_n) begin
                    en_cnt = 0;
                    have_sync = 1'b0;
                end else begin
                    en_cnt++;
                    if (o_SYNC) begin
                        period = en_cnt;
                        en_cnt = 0;
                    end
                end
                while (q.size() > 0) begin
                    e = q[0];
                    hit = 1'b0;
                    if (e.kind == K_ST) begin
                        compare(e.name, static_val(e.sel), e.val);
                        hit = 1'b1;
                    end else if (e.kind == K_CH && int'(o_CH) == e.ch) begin
                        compare(e.name, chv(o_FNUM, o_BLOCK, o_KON, o_SUSEN,
                                            o_INST, o_VOL), e.val);
                        hit = 1'b1;
                    end else if (e.kind == K_SYNC && o_SYNC && have_sync) begin
                        compare(e.name, 64'(period), e.val);
                        hit = 1'b1;
                    end
                    if (!hit)
                        break;
                    void'(q.pop_front());
                end
                if (ic_n && o_SYNC)
                    have_sync = 1'b1;
            end
        end
    end

    task automatic push_st(input string name, input int sel,
                           input logic [63:0] val);
        exp_t e;
        e.kind = K_ST; e.sel = sel; e.ch = 0; e.val = val; e.name = name;
        q.push_back(e);
    endtask

    task automatic push_ch(input string name, input int ch,
                           input logic [63:0] val);
        exp_t e;
        e.kind = K_CH; e.sel = 0; e.ch = ch; e.val = val; e.name = name;
        q.push_back(e);
    endtask

    task automatic push_sync();
        exp_t e;
        e.kind = K_SYNC; e.sel = 0; e.ch = 0; e.val = 64'd18;
        e.name = "sync_period";
        q.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d expectations left, required 0",
                     q.size());
            q.delete();
        end
    endtask

    task automatic wr(input logic ad, input logic [7:0] dv);
        @(posedge clk);
        #1 cs_n = 1'b0; wr_n = 1'b0; a0 = ad; d = dv;
        repeat (4) @(posedge clk);
        #1 cs_n = 1'b1; wr_n = 1'b1;
        repeat (6) @(posedge clk);
    endtask

    task automatic reg_wr(input logic [7:0] addr, input logic [7:0] data);
        wr(1'b0, addr);
        wr(1'b1, data);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        push_st("reset_patch", S_PATCH, 64'h0);
        push_st("reset_misc", S_MISC, 64'h0);
        push_st("xout", S_XOUT, 64'h1);
        drain();
        @(posedge clk);
        #1 ic_n = 1'b1;
        repeat (5) @(posedge clk);

        for (int a = 0; a < 8; a++)
            reg_wr(8'(a), 8'hFF);
        push_st("patch_all_ff", S_PATCH, 64'hFFFF_FFFF_FFFF_FFFF);
        drain();
        reg_wr(8'h00, 8'h5A);
        reg_wr(8'h07, 8'hA5);
        push_st("patch_order", S_PATCH, 64'hA5FF_FFFF_FFFF_FF5A);
        drain();

        reg_wr(8'h0E, 8'hFF);
        push_st("rhythm_ff", S_RHYTHM, 64'h3F);
        drain();
        reg_wr(8'h0E, 8'h00);
        push_st("rhythm_00", S_RHYTHM, 64'h00);
        drain();
        reg_wr(8'h0F, 8'hFF);
        push_st("test_ff", S_TEST, 64'hFF);
        drain();
        reg_wr(8'h0F, 8'h00);
        push_st("test_00", S_TEST, 64'h00);
        drain();

        for (int n = 0; n < 9; n++) begin
            reg_wr(8'h10 + 8'(n), 8'hAC);
            reg_wr(8'h20 + 8'(n), 8'h12);
        end
        for (int n = 0; n < 9; n++)
            push_ch($sformatf("ch%0d_fnum_ctrl", n), n,
                    chv(9'h0AC, 3'd1, 1'b1, 1'b0, 4'd0, 4'd0));
        drain();

        for (int n = 0; n < 9; n++)
            reg_wr(8'h30 + 8'(n), {4'(n), 4'hC});
        for (int n = 0; n < 9; n++)
            push_ch($sformatf("ch%0d_inst_vol", n), n,
                    chv(9'h0AC, 3'd1, 1'b1, 1'b0, 4'(n), 4'hC));
        push_sync();
        drain();

        reg_wr(8'h28, 8'hE1);
        push_ch("ch8_ctrl_e1", 8, chv(9'h1AC, 3'd0, 1'b0, 1'b1, 4'd8, 4'hC));
        drain();

        alt_en = 1'b1;
        repeat (3) @(posedge clk);
        push_st("altpatch", S_ALT, 64'h1);
        drain();

        reg_wr(8'h0F, 8'h11);
        wr(1'b1, 8'h22);
        push_st("test_relatch", S_TEST, 64'h22);
        drain();

        reg_wr(8'h19, 8'h55);
        reg_wr(8'h3F, 8'h55);
        push_st("inval_test", S_TEST, 64'h22);
        push_st("inval_rhythm", S_RHYTHM, 64'h00);
        push_st("inval_patch", S_PATCH, 64'hA5FF_FFFF_FFFF_FF5A);
        push_st("addr_latch", S_ADDR, 64'h3F);
        push_ch("inval_ch0", 0, chv(9'h0AC, 3'd1, 1'b1, 1'b0, 4'd0, 4'hC));
        drain();

        @(posedge clk);
        #1 cs_n = 1'b0; wr_n = 1'b0; a0 = 1'b1; d = 8'hFF;
        repeat (3) @(posedge clk);
        #1 ic_n = 1'b0; alt_en = 1'b0;
        push_st("midwr_reset_patch", S_PATCH, 64'h0);
        push_st("midwr_reset_misc", S_MISC, 64'h0);
        drain();
        @(posedge clk);
        #1 ic_n = 1'b1;
        repeat (5) @(posedge clk);
        #1 cs_n = 1'b1; wr_n = 1'b1;
        repeat (6) @(posedge clk);
        push_st("no_commit_patch", S_PATCH, 64'h0);
        push_st("no_commit_addr", S_ADDR, 64'h0);
        drain();

        reg_wr(8'h0E, 8'h15);
        push_st("post_reset_write", S_RHYTHM, 64'h15);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/opll_bus_regfile.md
Name: opll_bus_regfile

Overview:
- YM2413-compatible (OPLL) host-bus front end: CPU write interface, complete register file, and a 9-channel parameter scan driven by the phiM clock enable.
- Feeds the downstream operator/envelope/DAC engine, which lives in a separate block.
- Synthesis output (MO/RO) is out of scope here.

Parameters:
FULLY_SYNCHRONOUS, 1, 1: bus inputs pass a 2-flop synchroniser on i_XIN_EMUCLK; 0: single input register.
FAST_RESET, 1, 1: writes accepted immediately after reset release; 0: writes ignored for 72 phiM enables after release.
ALTPATCH_CONFIG_MODE, 0, 0: o_ALTPATCH follows registered i_ALTPATCH_EN continuously; 1: i_ALTPATCH_EN sampled once, on the first clock after reset release.

Ports:
i_XIN_EMUCLK  in  1  sole clock, all flops rising edge
i_IC_n  in  1  reset, asynchronous, active-low; clears all state
o_XOUT  out  1  ~i_XIN_EMUCLK, combinational
i_phiM_PCEN_n  in  1  active-low phiM clock enable, one EMUCLK wide
i_ALTPATCH_EN  in  1  alternate-patch-set request
i_CS_n  in  1  chip select, active-low
i_WR_n  in  1  write strobe, active-low
i_A0  in  1  0 = address, 1 = data
i_D  in  8  write data
o_D  out  8  current address latch (debug)
o_D_OE  out  1  constant 0; bus is write-only
o_ALTPATCH  out  1  alternate patch-set flag
o_PATCH  out  64  custom patch, regs 0x07..0x00, reg 0x00 in [7:0]
o_RHYTHM  out  6  reg 0x0E[5:0]
o_TEST  out  8  reg 0x0F
o_SYNC  out  1  high while slot counter = 0
o_CH  out  4  channel being presented, 0..8
o_FNUM  out  9  F-number of o_CH
o_BLOCK  out  3  block of o_CH
o_KON  out  1  key-on of o_CH
o_SUSEN  out  1  sustain of o_CH
o_INST  out  4  instrument of o_CH
o_VOL  out  4  volume of o_CH

Behaviour:
- Reset: every register, address latch, slot counter and output is 0, asynchronously. Exception: o_XOUT.
- Strobe: strobe = ~CS_n & ~WR_n after synchronisation.
  - While strobe is high, A0 and D are captured every clock.
  - On the strobe falling edge (release), commit the last captured A0/D.
  - Commit is independent of phiM.
- A0 = 0 commit: address latch <= D.
- A0 = 1 commit: write data to the latched address if the address is valid; otherwise discard.
  - Valid addresses: 0x00-0x07, 0x0E, 0x0F, 0x10-0x18, 0x20-0x28, 0x30-0x38. All others, e.g. 0x19 or 0x3F, are no-ops.
  - The address latch persists after a data write, so repeated data writes hit the same register.
- Field map, n = 0..8:
  - 0x1n: FNUM[7:0].
  - 0x2n: [5] SUSEN, [4] KON, [3:1] BLOCK, [0] FNUM[8]; bits [7:6] dropped.
  - 0x3n: [7:4] INST, [3:0] VOL.
  - 0x0E: bits [7:6] dropped.
- Simultaneous events: a commit and a scan read of the same channel in the same clock present the old value. The new value is visible on the next scan of that channel.
- Slot counter:
  - 0..17, increments on each clock with i_phiM_PCEN_n = 0, wraps 17 -> 0.
  - o_CH = counter >> 1.
  - Scan outputs registered, valid one EMUCLK after the enable.
- FAST_RESET = 0: a 7-bit hold counter loads 72 on reset release and decrements per phiM enable. Data commits are discarded while it is non-zero; address commits are still accepted.
- Reset mid-write: the pending commit is lost, and a strobe already active at release is not committed.

Optional Feature:
- OPLL_DBG_READBACK_EN defined: adds input i_DBG_ADDR[7:0] and output o_DBG_DATA[7:0].
  - o_DBG_DATA is the combinational raw byte at i_DBG_ADDR, with unstored bits read as 0.
  - Invalid addresses read 0x00.
- Undefined: both ports absent, no readback logic.

Decomposition:
- Package opll_pkg:
  - constants NUM_CH = 9, NUM_SLOTS = 18, RESET_HOLD = 72;
  - address-range localparams;
  - typedef ch_regs_t {fnum[8:0], block[2:0], kon, susen, inst[3:0], vol[3:0]}.
- One sub-module, opll_bus_if: synchroniser, capture, commit pulses.

Test Plan:
- Reset: release i_IC_n, then write A0=0 D=0x00 followed by A0=1 D=0xFF, repeated for 0x01-0x07 -> o_PATCH = 64'hFFFF_FFFF_FFFF_FFFF.
- Write 0x0E <- 0xFF, then 0x0E <- 0x00 -> o_RHYTHM goes 6'h3F then 6'h00.
- Write 0x0F <- 0xFF, then 0x0F <- 0x00 -> o_TEST goes 0xFF then 0x00.
- Write 0x1n <- 0xAC and 0x2n <- 0x12 for all n -> every channel: FNUM 0x0AC, BLOCK 1, KON 1, SUSEN 0.
- Write 0x3n <- {n, 4'hC} for n = 0..8 -> at o_CH = n: INST = n, VOL = 0xC; o_SYNC pulses once per 18 enables.
- Write to 0x19, then assert i_IC_n low mid-strobe -> no register change; all outputs return to 0.
